mdu_seq: RTL and testbench

- Multi-cycle unsigned multiply/divide sequencer for the integer core.
- Time-shares one internal (WIDTH+1)-bit ripple adder/subtractor instance: shift-add for multiply, restoring subtract for divide. One adder operation per cycle.
- Sits beside the ALU in execute. Has valid/ready handshakes on the operand side and the result side. Unused by single-cycle ops.

---
 rtl/mdu_seq.sv | 169 ++++++++++++++++
 tb/tb_mdu_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// Multi-cycle unsigned multiply/divide sequencer.
// A single (WIDTH+1)-bit ripple adder/subtractor is shared between shift-add
// multiply and restoring divide, with one adder operation per cycle.
module mdu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int unsigned AW = WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // hi/lo hold {acc_hi, acc_lo} for multiply and {rem, quo} for divide.
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [AW-1:0]    add_x;
    logic [AW-1:0]    add_y;
    logic             add_sub;
    logic [AW-1:0]    add_s;

    // Adder operand selection: op[1] picks divide (subtract) vs multiply (add).
    always_comb begin
        add_sub = op_q[1];
        add_x   = {1'b0, hi_q};
        add_y   = '0;
        if (op_q[1]) begin
            add_x = {hi_q, lo_q[WIDTH-1]};
            add_y = {1'b0, b_q};
        end else if (lo_q[0]) begin
            add_y = {1'b0, b_q};
        end
    end

    // Shared ripple-carry adder/subtractor; subtract is x + ~y + 1.
    always_comb begin
        logic carry;
        logic yb;
        carry = add_sub;
        add_s = '0;
        for (int i = 0; i < int'(AW); i++) begin
            yb       = add_y[i] ^ add_sub;
            add_s[i] = add_x[i] ^ yb ^ carry;
            carry    = (add_x[i] & yb) | (add_x[i] & carry) | (yb & carry);
        end
    end

    // Next-state, datapath update and registered-output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && !flush) begin
                    op_d    = op;
                    b_d     = b;
                    hi_d    = '0;
                    lo_d    = a;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (op_q[1]) begin
                    // Restoring divide: keep the difference only if it did not borrow.
                    if (!add_s[AW-1]) begin
                        hi_d = add_s[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = add_x[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    // Shift-add multiply: carry lands in the accumulator MSB.
                    hi_d = add_s[AW-1:1];
                    lo_d = {add_s[0], lo_q[WIDTH-1:1]};
                end
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (flush) begin
            state_d = ST_IDLE;
        end

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
        result_d    = '0;
        if (state_d == ST_DONE) begin
            result_d = op_d[0] ? hi_d : lo_d;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            b_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            b_q         <= b_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            result_q    <= result_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: vector table plus handshake/abort sequences.
module tb_mdu_seq;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         busy;

    int checks;
    int errors;

    mdu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op with out_ready=1; returns the result and the edge count
    // from the accepting edge (edge 1) to the edge that raised out_valid.
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] res, output int edges);
        @(negedge clk);
        check("in_ready_before_issue", W'(in_ready), W'(1));
        in_valid  = 1'b1;
        op        = o;
        a         = x;
        b         = y;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        edges    = 1;
        while (!out_valid && edges < 200) begin
            @(posedge clk);
            edges++;
            #1;
        end
        res = result;
        @(posedge clk);
        #1;
        check("out_valid_after_xfer", W'(out_valid), W'(0));
        check("in_ready_after_xfer", W'(in_ready), W'(1));
    endtask

    initial begin
        logic [W-1:0] res;
        int           edges;
        int           hs;
        bit           seen;

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 2'b00;
        a         = '0;
        b         = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        vecs[0]  = '{"mul_7x6",        2'b00, 32'd7,        32'd6,        32'h0000002A};
        vecs[1]  = '{"mulhu_ff_ff",    2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[2]  = '{"mul_ff_ff",      2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        vecs[3]  = '{"divu_100_7",     2'b10, 32'd100,      32'd7,        32'h0000000E};
        vecs[4]  = '{"remu_100_7",     2'b11, 32'd100,      32'd7,        32'h00000002};
        vecs[5]  = '{"divu_5_0",       2'b10, 32'd5,        32'd0,        32'hFFFFFFFF};
        vecs[6]  = '{"remu_5_0",       2'b11, 32'd5,        32'd0,        32'h00000005};
        vecs[7]  = '{"mulhu_shift",    2'b01, 32'h12345678, 32'h00000010, 32'h00000001};
        vecs[8]  = '{"mul_shift",      2'b00, 32'h12345678, 32'h00000010, 32'h23456780};
        vecs[9]  = '{"divu_max_1",     2'b10, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF};
        vecs[10] = '{"remu_max_16",    2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F};

        // Reset values.
        #12;
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_result", result, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors: result and latency.
        for (int i = 0; i < NVEC; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, edges);
            check({vecs[i].name, "_result"}, res, vecs[i].exp);
            check({vecs[i].name, "_latency"}, W'(edges), W'(33));
        end

        // Backpressure: MUL 3x5 held in DONE, stray in_valid ignored.
        @(negedge clk);
        in_valid  = 1'b1;
        op        = 2'b00;
        a         = 32'd3;
        b         = 32'd5;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        edges = 0;
        while (!out_valid && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        check("bp_out_valid_seen", W'(out_valid), W'(1));
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            op       = 2'b10;
            a        = 32'd9;
            b        = 32'd3;
            @(negedge clk);
            check("bp_result_held", result, 32'd15);
            check("bp_busy", W'(busy), W'(1));
            check("bp_in_ready_low", W'(in_ready), W'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        hs = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid && out_ready) hs++;
            @(negedge clk);
        end
        check("bp_one_handshake", W'(hs), W'(1));
        check("bp_idle_busy", W'(busy), W'(0));
        check("bp_idle_in_ready", W'(in_ready), W'(1));

        // Flush in IDLE with in_valid must not accept.
        in_valid = 1'b1;
        flush    = 1'b1;
        op       = 2'b10;
        a        = 32'd9;
        b        = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        check("idle_flush_no_accept_busy", W'(busy), W'(0));
        check("idle_flush_in_ready", W'(in_ready), W'(1));

        // Flush at RUN count=10: accept edge gives count 0, ten more edges give 10.
        in_valid = 1'b1;
        op       = 2'b10;
        a        = 32'd1000;
        b        = 32'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_in_ready", W'(in_ready), W'(1));
        check("flush_busy", W'(busy), W'(0));
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("flush_no_out_valid", W'(seen), W'(0));
        do_op(2'b10, 32'd9, 32'd3, res, edges);
        check("post_flush_divu_9_3", res, 32'd3);
        check("post_flush_latency", W'(edges), W'(33));

        // Asynchronous reset mid-RUN.
        @(negedge clk);
        in_valid = 1'b1;
        op       = 2'b00;
        a        = 32'd11;
        b        = 32'd13;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("pre_rst_busy", W'(busy), W'(1));
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", W'(in_ready), W'(1));
        check("arst_busy", W'(busy), W'(0));
        check("arst_out_valid", W'(out_valid), W'(0));
        check("arst_result", result, '0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(2'b00, 32'd11, 32'd13, res, edges);
        check("post_rst_mul_11_13", res, 32'd143);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
